// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter and sequencer for a 4:1 Width-bit mux.
// Grants one of four requesters (a..d) at a time, steers the mux through a
// registered counter_sel, and presents the result as a valid/ready stream
// with per-requester acknowledges. Bursts are capped at MAX_BURST beats.
// Optional build macro ARB_FIXED_PRIO_EN: fixed priority a>b>c>d instead of
// round-robin; the burst limit still applies.
module rr_mux_arbiter #(
  parameter int Width     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [Width-1:0] c,
  input  logic [Width-1:0] d,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  output logic             out_last,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [1:0]       counter_sel
);

  localparam int CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state, state_n;
  logic [3:0]   gnt_n;
  logic [1:0]   sel_n;
  logic         valid_n;
  logic [CW-1:0] beat_cnt, cnt_n;
  logic [1:0]   last_grant, ptr_n;
  logic [1:0]   base_idle, base_rel;
  logic         beat_done;

  // First set bit of r searching base+1, base+2, base+3, base+4 (mod 4).
  // Iterating from the farthest slot down lets the nearest slot win.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] w;
    logic [1:0] idx;
    w = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  // Searching from slot 3 always starts at requester a: fixed a>b>c>d.
  assign base_idle = 2'd3;
  assign base_rel  = 2'd3;
`else
  // Round-robin: idle search starts after the last release; on release the
  // pointer becomes the releasing requester, giving it lowest priority.
  assign base_idle = last_grant;
  assign base_rel  = counter_sel;
`endif

  assign beat_done = out_valid & out_ready;
  assign out_last  = out_valid & (last[counter_sel] | (beat_cnt == CNT_MAX));
  // A reset edge aborts the burst, so the beat in flight is not acknowledged.
  assign ack       = gnt & {4{out_ready & ~rst}};

  // Output mux steered by the registered select.
  always_comb begin
    unique case (counter_sel)
      2'd0:    out_data = a;
      2'd1:    out_data = b;
      2'd2:    out_data = c;
      default: out_data = d;
    endcase
  end

  // Next-state logic: grant from IDLE, count beats, release and re-arbitrate.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_n = state;
    gnt_n   = gnt;
    sel_n   = counter_sel;
    valid_n = out_valid;
    cnt_n   = beat_cnt;
    ptr_n   = last_grant;
    unique case (state)
      IDLE: begin
        if (|req) begin
          sel_n   = pick(req, base_idle);
          gnt_n   = 4'b0001 << pick(req, base_idle);
          valid_n = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (beat_done) begin
          if (out_last) begin
            ptr_n = counter_sel;
            cnt_n = '0;
            if (|req) begin
              sel_n = pick(req, base_rel);
              gnt_n = 4'b0001 << pick(req, base_rel);
            end else begin
              gnt_n   = 4'b0000;
              valid_n = 1'b0;
              state_n = IDLE;
            end
          end else begin
            cnt_n = beat_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with synchronous reset; pointer resets so a wins first.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state       <= IDLE;
      gnt         <= 4'b0000;
      counter_sel <= 2'd0;
      out_valid   <= 1'b0;
      beat_cnt    <= '0;
      last_grant  <= 2'd3;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      counter_sel <= sel_n;
      out_valid   <= valid_n;
      beat_cnt    <= cnt_n;
      last_grant  <= ptr_n;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_rr_mux_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req, last, gnt, ack;
  logic [W-1:0] a, b, c, d, out_data;
  logic         out_ready, out_valid, out_last;
  logic [1:0]   counter_sel;

  int vectors = 0;
  int miscompares = 0;

  rr_mux_arbiter #(.Width(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .gnt(gnt), .ack(ack), .counter_sel(counter_sel)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Reference winner: first requester at or after the slot following ptr.
  function automatic int winner(input logic [3:0] r, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
    for (int j = 0; j < 4; j++) if (r[j]) return j;
`else
    for (int i = 1; i <= 4; i++) if (r[(ptr + i) % 4]) return (ptr + i) % 4;
`endif
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; last = '0; out_ready = 1'b0;
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    tick(); tick();
    vectors++;
    if ({gnt, out_valid, counter_sel} !== {4'b0000, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state got gnt=%b valid=%b sel=%0d want gnt=0000 valid=0 sel=0",
               gnt, out_valid, counter_sel);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({gnt, out_valid, counter_sel} !== {4'b0001, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL first_grant got gnt=%b valid=%b sel=%0d want gnt=0001 valid=1 sel=0",
               gnt, out_valid, counter_sel);
    end
  endtask

  task automatic test_rotate();
    do_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({counter_sel, ack, out_valid, out_last} !== {2'(i % 4), 4'(1 << (i % 4)), 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL rotate[%0d] got sel=%0d ack=%b valid=%b last=%b want sel=%0d ack=%b valid=1 last=1",
                 i, counter_sel, ack, out_valid, out_last, i % 4, 4'(1 << (i % 4)));
      end
    end
  endtask

  task automatic test_burst();
    logic [1:0] es;
    do_reset();
    req = 4'b0101; last = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      es = (i >= 4 && i < 8) ? 2'd2 : 2'd0;
      vectors++;
      if ({counter_sel, out_valid, out_last} !== {es, 1'b1, 1'(i % 4 == 3)}) begin
        miscompares++;
        $display("FAIL burst[%0d] got sel=%0d valid=%b last=%b want sel=%0d valid=1 last=%b",
                 i, counter_sel, out_valid, out_last, es, i % 4 == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    b = 8'h5a; req = 4'b0010; last = 4'b0000; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({gnt, counter_sel, out_data, ack, out_last} !== {4'b0010, 2'd1, 8'h5a, 4'b0000, 1'b0}) begin
        miscompares++;
        $display("FAIL stall[%0d] got gnt=%b sel=%0d data=%h ack=%b last=%b want 0010/1/5a/0000/0",
                 i, gnt, counter_sel, out_data, ack, out_last);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if ({ack, out_last} !== {4'b0010, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_release got ack=%b last=%b want ack=0010 last=0", ack, out_last);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1000; last = 4'b0000; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1; req = 4'b1010;
    #1;
    vectors++;
    if (ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ack got ack=%b want 0000", ack);
    end
    tick();
    rst = 1'b0;
    vectors++;
    if ({gnt, out_valid} !== {4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_abort got gnt=%b valid=%b want 0000/0", gnt, out_valid);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_pointer got gnt=%b want 0010", gnt);
    end
  endtask

`ifdef ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (counter_sel !== 2'd0) begin
        miscompares++;
        $display("FAIL fixed[%0d] got sel=%0d want 0", i, counter_sel);
      end
    end
    req[0] = 1'b0;
    tick();
    vectors++;
    if ({gnt, counter_sel} !== {4'b0010, 2'd1}) begin
      miscompares++;
      $display("FAIL fixed_drop got gnt=%b sel=%0d want 0010/1", gnt, counter_sel);
    end
  endtask
`endif

  // Random traffic that obeys the hold-until-last-ack protocol, compared
  // each cycle against a model tracking owner, beat count and pointer.
  task automatic test_random(input int n);
    logic [3:0]   rel, e_gnt, e_ack;
    logic [W-1:0] dv [4];
    logic         m_busy, e_last;
    int           m_sel, m_cnt, m_ptr;
    do_reset();
    m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_ptr = 3; rel = '0;
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < 4; r++) begin
        if (!req[r]) req[r] = ($urandom_range(3) == 0);
        else if (rel[r]) req[r] = 1'($urandom_range(1));
      end
      last = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      rst = ($urandom_range(149) == 0);
      @(negedge clk);
      dv = '{a, b, c, d};
      e_gnt  = m_busy ? 4'(1 << m_sel) : 4'b0000;
      e_last = m_busy && (last[m_sel] || m_cnt == MB - 1);
      e_ack  = rst ? 4'b0000 : (e_gnt & {4{out_ready}});
      vectors++;
      if ({out_valid, gnt, counter_sel, out_last, ack, out_data} !==
          {m_busy, e_gnt, 2'(m_sel), e_last, e_ack, dv[m_sel]}) begin
        miscompares++;
        $display("FAIL random[%0d] got v=%b g=%b s=%0d l=%b k=%b d=%h want v=%b g=%b s=%0d l=%b k=%b d=%h",
                 i, out_valid, gnt, counter_sel, out_last, ack, out_data,
                 m_busy, e_gnt, m_sel, e_last, e_ack, dv[m_sel]);
      end
      rel = '0;
      if (rst) begin
        m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_ptr = 3;
      end else if (!m_busy) begin
        if (req != 0) begin
          m_sel = winner(req, m_ptr);
          m_busy = 1'b1;
        end
      end else if (out_ready) begin
        if (e_last) begin
          rel[m_sel] = 1'b1;
          m_ptr = m_sel;
          m_cnt = 0;
          if (req != 0) m_sel = winner(req, m_ptr);
          else m_busy = 1'b0;
        end else begin
          m_cnt++;
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
`ifndef ARB_FIXED_PRIO_EN
    test_rotate();
    test_burst();
`else
    test_fixed_prio();
`endif
    test_backpressure();
    test_reset_mid_burst();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
